// File: rtl/haeuslermarkus_fir_filter_if.sv
// Pad-ring bundle for the FIR filter: data/strobe inputs and filtered output.
// The master drives the inputs; the slave is the filter.
interface haeuslermarkus_fir_filter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/haeuslermarkus_fir_filter.sv
// 4-tap signed 8-bit FIR with run-time loadable Q1.7 coefficients and a registered output.
// Define FIR_SAT_EN to saturate the output to [-128,127]; otherwise the output wraps.
module haeuslermarkus_fir_filter #(
    parameter int unsigned Taps  = 4,
    parameter int unsigned Shift = 7
) (
    input logic                          clk,
    input logic                          rst_n,
    haeuslermarkus_fir_filter_if.slave   bus
);

    localparam logic signed [7:0] CoefReset = 8'sd32;

    logic signed [7:0]  x_q [Taps];
    logic signed [7:0]  x_d [Taps];
    logic signed [7:0]  c_q [Taps];
    logic signed [7:0]  c_d [Taps];
    logic signed [15:0] prod [Taps];
    logic signed [17:0] acc;
    logic signed [17:0] y_full;
    logic [7:0]         y_fmt;
    logic [7:0]         out_q;
    logic               accept;
    logic               pend_q;
    logic               valid_q;

    logic sample_valid, coef_wr, clear;
    logic [1:0] coef_idx;

    assign sample_valid = bus.uio_in[0];
    assign coef_wr      = bus.uio_in[1];
    assign coef_idx     = bus.uio_in[3:2];
    assign clear        = bus.uio_in[4];

    always_comb begin
        for (int i = 0; i < int'(Taps); i++) begin
            x_d[i] = x_q[i];
            c_d[i] = c_q[i];
        end
        accept = 1'b0;
        if (bus.ena) begin
            if (coef_wr) begin
                c_d[coef_idx] = bus.ui_in;
            end else if (clear) begin
                for (int i = 0; i < int'(Taps); i++) begin
                    x_d[i] = '0;
                end
            end else if (sample_valid) begin
                for (int i = int'(Taps) - 1; i > 0; i--) begin
                    x_d[i] = x_q[i-1];
                end
                x_d[0] = bus.ui_in;
                accept = 1'b1;
            end
        end
    end

    // 18-bit accumulator holds the worst case 4 * (-128 * -128) without overflow.
    always_comb begin
        acc = '0;
        for (int i = 0; i < int'(Taps); i++) begin
            prod[i] = c_q[i] * x_q[i];
            acc     = acc + {{2{prod[i][15]}}, prod[i]};
        end
        y_full = acc >>> Shift;
    end

`ifdef FIR_SAT_EN
    always_comb begin
        if (y_full > 18'sd127) begin
            y_fmt = 8'h7F;
        end else if (y_full < -18'sd128) begin
            y_fmt = 8'h80;
        end else begin
            y_fmt = y_full[7:0];
        end
    end
`else
    assign y_fmt = y_full[7:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Taps); i++) begin
                x_q[i] <= '0;
                c_q[i] <= CoefReset;
            end
            out_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(Taps); i++) begin
                x_q[i] <= x_d[i];
                c_q[i] <= c_d[i];
            end
            out_q   <= y_fmt;
            // Valid trails the accept by two edges: one to shift in, one to register y.
            pend_q  <= accept;
            valid_q <= pend_q;
        end
    end

    assign bus.uo_out  = out_q;
    assign bus.uio_out = {valid_q, 7'b0};
    assign bus.uio_oe  = 8'h80;

    logic unused_ok;
    assign unused_ok = ^{bus.uio_in[7:5], y_full[17:8]};

endmodule

// File: tb/tb_haeuslermarkus_fir_filter.sv
// Self-checking bench for haeuslermarkus_fir_filter: directed steps plus randomized traffic
// compared against an arithmetic reference model.
module tb_haeuslermarkus_fir_filter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    haeuslermarkus_fir_filter_if bus ();

    haeuslermarkus_fir_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] SV  = 8'h01;
    localparam logic [7:0] CLR = 8'h10;

    // Reference model state: plain integers, newest sample at mx[0].
    int mx [4];
    int mc [4];
    bit m_pend;

    function automatic logic [7:0] fmt_ref(input int acc);
        int y;
        y = acc / 128;
        if ((acc % 128 != 0) && (acc < 0)) y = y - 1;
`ifdef FIR_SAT_EN
        if (y > 127) y = 127;
        if (y < -128) y = -128;
`endif
        return 8'(y);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = 0;
            mc[i] = 32;
        end
        m_pend = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit e, input logic [7:0] d, input logic [7:0] ctl);
        int         acc;
        logic [7:0] exp_out;
        bit         exp_valid;
        bus.ena    = e;
        bus.ui_in  = d;
        bus.uio_in = ctl;
        @(posedge clk);
        acc = 0;
        for (int i = 0; i < 4; i++) acc += mc[i] * mx[i];
        exp_out   = fmt_ref(acc);
        exp_valid = m_pend;
        m_pend    = 1'b0;
        if (e) begin
            if (ctl[1]) begin
                mc[int'(ctl[3:2])] = int'($signed(d));
            end else if (ctl[4]) begin
                for (int i = 0; i < 4; i++) mx[i] = 0;
            end else if (ctl[0]) begin
                mx[3] = mx[2];
                mx[2] = mx[1];
                mx[1] = mx[0];
                mx[0] = int'($signed(d));
                m_pend = 1'b1;
            end
        end
        #1;
        check("uo_out", bus.uo_out, exp_out);
        check("uio_out", bus.uio_out, {exp_valid, 7'b0});
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        bus.ena    = 1'b0;
        bus.ui_in  = '0;
        bus.uio_in = '0;
        rst_n      = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("reset_uo_out", bus.uo_out, 8'h00);
        check("reset_uio_out", bus.uio_out, 8'h00);
        check("reset_uio_oe", bus.uio_oe, 8'h80);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 8'h00, 8'h00);
        step(1'b1, 8'h00, 8'h00);

        // Step response through the default moving average.
        repeat (4) step(1'b1, 8'd100, SV);
        step(1'b1, 8'h00, 8'h00);
        check("step_final", bus.uo_out, 8'd100);

        // Impulse through c0 = 127 only.
        step(1'b1, 8'd127, 8'h02);
        step(1'b1, 8'd0, 8'h06);
        step(1'b1, 8'd0, 8'h0A);
        step(1'b1, 8'd0, 8'h0E);
        step(1'b1, 8'd0, CLR);
        step(1'b1, 8'd100, SV);
        step(1'b1, 8'd0, SV);
        check("impulse_99", bus.uo_out, 8'd99);
        repeat (3) step(1'b1, 8'd0, SV);

        // Maximum positive accumulator.
        for (int i = 0; i < 4; i++) step(1'b1, 8'd127, 8'(8'h02 | (i << 2)));
        repeat (4) step(1'b1, 8'd127, SV);
        step(1'b1, 8'h00, 8'h00);
`ifdef FIR_SAT_EN
        check("max_sat", bus.uo_out, 8'h7F);
`else
        check("max_wrap", bus.uo_out, 8'hF8);
`endif

        // Floor behaviour on negative results.
        for (int i = 0; i < 4; i++) step(1'b1, 8'd32, 8'(8'h02 | (i << 2)));
        step(1'b1, 8'h00, CLR);
        step(1'b1, 8'hFF, SV);
        step(1'b1, 8'h00, 8'h00);
        check("neg_one_floor", bus.uo_out, 8'hFF);
        step(1'b1, 8'h00, CLR);
        step(1'b1, 8'h9C, SV);
        step(1'b1, 8'h00, 8'h00);
        check("neg_100", bus.uo_out, 8'hE7);

        // coef_wr wins over sample_valid; ena=0 ignores every strobe.
        step(1'b1, 8'd64, 8'h03);
        step(1'b1, 8'h00, 8'h00);
        step(1'b0, 8'd50, SV);
        step(1'b0, 8'd1, 8'h02);
        step(1'b0, 8'd0, CLR);
        step(1'b1, 8'h00, 8'h00);
        step(1'b1, 8'd40, SV);
        step(1'b1, 8'd40, SV);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #2;
        check("midreset_uo_out", bus.uo_out, 8'h00);
        check("midreset_uio_out", bus.uio_out, 8'h00);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 8'd80, SV);
        step(1'b1, 8'h00, 8'h00);
        check("after_reset_coef32", bus.uo_out, 8'd20);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ctl;
            int         r;
            r   = int'($urandom_range(0, 99));
            ctl = 8'($urandom) & 8'hEC;
            if (r < 60)      ctl = ctl | SV;
            else if (r < 75) ctl = ctl | 8'h02;
            else if (r < 80) ctl = ctl | CLR;
            step(($urandom_range(0, 9) != 0), 8'($urandom), ctl);
        end
        check("uio_oe_end", bus.uio_oe, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
